// File: rtl/led_display_row_driver.sv
// ---------------------------------------------------------------------------
// led_display_row_driver
//
// Drives one row pair of a HUB75-style LED panel. A 64-column row is
// captured into a pending buffer, moved into a shift register, clocked out
// column by column, then the panel is blanked, latched and enabled for a
// fixed on-time. The pending buffer accepts the next row at any time, so
// rows can be streamed back to back with a single idle cycle between them.
//
// Ports
//   clk_in          system clock, rising edge
//   reset_in        asynchronous active-high reset
//   row_in          64 columns x {r0,g0,b0,r1,g1,b1}, column c at [383-6c -: 6]
//   row_valid_in    row_in / row_address_in valid
//   row_address_in  panel row-pair index for row_in
//   row_ready_out   pending buffer empty, a row can be accepted
//   hub_rgb0_out    upper-half {r,g,b}
//   hub_rgb1_out    lower-half {r,g,b}
//   hub_addr_out    panel row address
//   hub_clk_out     panel shift clock
//   hub_lat_out     panel latch, active-high
//   hub_oe_n_out    panel output enable, active-low
//
// state       | meaning
// ------------+-------------------------------------------------------------
// SS_IDLE     | wait for a pending row, move it into the shift register
// SS_SHIFT    | clock 64 columns out (low phase, then high phase)
// SS_BLANK    | output disabled, new address presented
// SS_LATCH    | latch pulse, output still disabled
// SS_DISPLAY  | output enabled for the on-time
// ---------------------------------------------------------------------------
module led_display_row_driver #(
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int LATCH_CYCLES = 2,
    parameter int ON_CYCLES    = 256
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic [383:0] row_in,
    input  logic         row_valid_in,
    input  logic [3:0]   row_address_in,
    output logic         row_ready_out,
    output logic [2:0]   hub_rgb0_out,
    output logic [2:0]   hub_rgb1_out,
    output logic [3:0]   hub_addr_out,
    output logic         hub_clk_out,
    output logic         hub_lat_out,
    output logic         hub_oe_n_out
);

    localparam int MAX_A = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int MAX_B = (LATCH_CYCLES > ON_CYCLES) ? LATCH_CYCLES : ON_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    // One shared down-counter; each phase loads (length - 1) and advances at 0.
    localparam logic [TW-1:0] DIV_LD   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] LATCH_LD = TW'(LATCH_CYCLES - 1);
    localparam logic [TW-1:0] ON_LD    = TW'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        SS_IDLE,
        SS_SHIFT,
        SS_BLANK,
        SS_LATCH,
        SS_DISPLAY
    } state_t;

    state_t         state_q, state_d;
    logic           pend_full_q, pend_full_d;
    logic [383:0]   pend_row_q, pend_row_d;
    logic [3:0]     pend_addr_q, pend_addr_d;
    logic           ready_q, ready_d;
    logic [383:0]   shift_q, shift_d;
    logic [3:0]     shift_addr_q, shift_addr_d;
    logic [3:0]     addr_q, addr_d;
    logic [5:0]     col_q, col_d;
    logic           phase_q, phase_d;
    logic [TW-1:0]  timer_q, timer_d;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= SS_IDLE;
            pend_full_q  <= 1'b0;
            pend_row_q   <= '0;
            pend_addr_q  <= '0;
            ready_q      <= 1'b1;
            shift_q      <= '0;
            shift_addr_q <= '0;
            addr_q       <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            pend_full_q  <= pend_full_d;
            pend_row_q   <= pend_row_d;
            pend_addr_q  <= pend_addr_d;
            ready_q      <= ready_d;
            shift_q      <= shift_d;
            shift_addr_q <= shift_addr_d;
            addr_q       <= addr_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_full_d  = pend_full_q;
        pend_row_d   = pend_row_q;
        pend_addr_d  = pend_addr_q;
        shift_d      = shift_q;
        shift_addr_d = shift_addr_q;
        addr_d       = addr_q;
        col_d        = col_q;
        phase_d      = phase_q;
        timer_d      = timer_q;

        // ready_q mirrors !pend_full_q, so a capture never collides with the
        // IDLE move below (the move only happens while the buffer is full).
        if (row_valid_in && ready_q) begin
            pend_full_d = 1'b1;
            pend_row_d  = row_in;
            pend_addr_d = row_address_in;
        end

        case (state_q)
            SS_IDLE: begin
                if (pend_full_q) begin
                    shift_d      = pend_row_q;
                    shift_addr_d = pend_addr_q;
                    pend_full_d  = 1'b0;
                    col_d        = '0;
                    phase_d      = 1'b0;
                    timer_d      = DIV_LD;
                    state_d      = SS_SHIFT;
                end
            end
            SS_SHIFT: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    timer_d = DIV_LD;
                end else if (col_q == 6'd63) begin
                    // Last column stays on the rgb pins while blanked.
                    phase_d = 1'b0;
                    timer_d = BLANK_LD;
                    addr_d  = shift_addr_q;
                    state_d = SS_BLANK;
                end else begin
                    col_d   = col_q + 6'd1;
                    phase_d = 1'b0;
                    timer_d = DIV_LD;
                    shift_d = {shift_q[377:0], 6'b0};
                end
            end
            SS_BLANK: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    timer_d = LATCH_LD;
                    state_d = SS_LATCH;
                end
            end
            SS_LATCH: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    timer_d = ON_LD;
                    state_d = SS_DISPLAY;
                end
            end
            SS_DISPLAY: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d = SS_IDLE;
                end
            end
            default: begin
                state_d = SS_IDLE;
            end
        endcase

        ready_d = ~pend_full_d;
    end

    assign row_ready_out = ready_q;
    assign hub_rgb0_out  = shift_q[383:381];
    assign hub_rgb1_out  = shift_q[380:378];
    assign hub_addr_out  = addr_q;
    assign hub_clk_out   = (state_q == SS_SHIFT) && phase_q;
    assign hub_lat_out   = (state_q == SS_LATCH);
    assign hub_oe_n_out  = (state_q != SS_DISPLAY);

endmodule
